// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative 32-bit divider.
//   * bus widths (REG_W / DREG_W) and the matching reg_t / dreg_t types
//   * FSM state encoding (free, divide-by-zero, iterating, result held)
//   * ready / start level names used by the divider and the EX stage
//   * abs_if_signed(): magnitude of an operand when dividing signed
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DREG_W = 64;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DREG_W-1:0] dreg_t;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Two's-complement magnitude of a signed operand; unsigned operands pass.
  // -2^31 maps to 32'h80000000, which is the correct unsigned magnitude.
  function automatic reg_t abs_if_signed(input logic is_signed, input reg_t v);
    return (is_signed && v[REG_W-1]) ? (~v + reg_t'(1)) : v;
  endfunction

endpackage

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- multi-cycle restoring divider for the EX stage (DIV / DIVU).
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend (sampled on the accept edge only)
//   opdata2_i     divisor  (sampled on the accept edge only)
//   start_i       divide request, held high until ready_o is seen
//   annul_i       cancel the request / in-flight divide (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Timing: accept edge E0 loads the operands, E1..E32 perform one quotient
// bit each, E33 applies sign correction and raises ready_o. A zero divisor
// skips the iteration and reports a zero result one clock after accept.
// -----------------------------------------------------------------------------
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [64:0] working_q;     // {partial remainder, dividend bits / quotient}
  reg_t        divisor_q;     // divisor magnitude
  logic        neg_quot_q;    // negate quotient at the end
  logic        neg_rem_q;     // negate remainder at the end
  dreg_t       result_q;
  logic        ready_q;

  logic [32:0] diff_d;
  logic [64:0] working_d;
  reg_t        quot_fix;
  reg_t        rem_fix;

  // One restoring step. The shifted partial remainder in working_q[64:32]
  // is always below 2*divisor, so bit 32 of the 33-bit difference is a
  // reliable borrow flag.
  always_comb begin
    diff_d = working_q[64:32] - {1'b0, divisor_q};
    if (!diff_d[32]) begin
      working_d = {diff_d[31:0], working_q[31:0], 1'b1};
    end else begin
      working_d = {working_q[63:0], 1'b0};
    end
  end

  // After 32 steps the quotient sits in [31:0] and the remainder in [64:33].
  always_comb begin
    quot_fix = neg_quot_q ? (~working_q[31:0] + reg_t'(1)) : working_q[31:0];
    rem_fix  = neg_rem_q  ? (~working_q[64:33] + reg_t'(1)) : working_q[64:33];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working register is a handful of flops, not a memory, so
      // it is cleared with the rest of the state on reset.
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      working_q  <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q    <= DIV_ON;
              cnt_q      <= '0;
              working_q  <= {32'b0, abs_if_signed(signed_div_i, opdata1_i), 1'b0};
              divisor_q  <= abs_if_signed(signed_div_i, opdata2_i);
              neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem_q  <= signed_div_i && opdata1_i[31];
            end
          end
        end

        DIV_BYZERO: begin
          result_q <= '0;
          if (annul_i) begin
            state_q <= DIV_FREE;
            ready_q <= DIV_RESULT_NOT_READY;
          end else begin
            state_q <= DIV_END;
            ready_q <= DIV_RESULT_READY;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end else if (cnt_q != 6'd32) begin
            working_q <= working_d;
            cnt_q     <= cnt_q + 6'd1;
          end else begin
            state_q  <= DIV_END;
            result_q <= {rem_fix, quot_fix};
            ready_q  <= DIV_RESULT_READY;
          end
        end

        DIV_END: begin
          // Result is held until EX drops its request.
          if (start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state_q  <= DIV_FREE;
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
